keypoint_reader: RTL and testbench
==================================

Name: keypoint_reader

Overview:
- Read-side consumer of the keypoint SRAM that the detect/filter stage fills.
- After detection completes, walks keypoint addresses 0..kp_count-1, splits each 19-bit word into row/col, and streams them on a valid/ready interface to the downstream descriptor/orientation stage.
- Handles the 1-cycle SRAM read latency and downstream backpressure through a small credit-controlled output FIFO.
- Sustains one keypoint per cycle while kp_ready is held high.

Parameters:
- ADDR_W, 11, keypoint SRAM address width (2K entries).
- ROW_W, 9, row field width.
- COL_W, 10, column field width.
- FIFO_DEPTH, 4, output FIFO entries; must be >= 2, power of two.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin streaming; ignored while busy
- kp_count  in  ADDR_W+1  number of valid keypoints, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last keypoint handshake
- keypoint_re  out  1  SRAM read enable
- keypoint_addr  out  ADDR_W  SRAM read address
- keypoint_dout  in  ROW_W+COL_W  SRAM read data, valid 1 cycle after keypoint_re
- kp_valid  out  1  output stream valid
- kp_ready  in  1  downstream ready
- kp_row  out  ROW_W  keypoint row = keypoint_dout[18:10]
- kp_col  out  COL_W  keypoint column = keypoint_dout[9:0]
- kp_last  out  1  marks the final keypoint of the set

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, FIFO empty, counters 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on start, latch count = min(kp_count, 2^ADDR_W), clear rd_idx and out_idx, go to READ; busy=1 from the next cycle.
  - If the latched count is 0, go straight to DONE with no SRAM reads.
- READ issues a read when rd_idx < count and (fifo_occ + inflight - pop) < FIFO_DEPTH.
  - pop = kp_valid && kp_ready in the same cycle.
  - On issue: keypoint_re=1, keypoint_addr=rd_idx, rd_idx++.
  - inflight is a 1-bit register that mirrors keypoint_re delayed by one cycle.
  - When rd_idx reaches count, go to DRAIN.
- Capture: in the cycle after keypoint_re, push keypoint_dout into the FIFO unconditionally. The credit check guarantees space.
- FIFO: registered head. kp_valid = occupancy != 0. kp_row/kp_col come from the head entry.
  - Simultaneous push and pop on a full FIFO is legal; occupancy stays unchanged.
- kp_last = kp_valid && (out_idx == count-1). out_idx increments on each pop.
- DRAIN: no reads. When the pop of the last entry occurs (kp_last && kp_ready), go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 from that cycle, return to IDLE.
- kp_valid, kp_row and kp_col are held stable while kp_valid && !kp_ready (AXI-style: no retraction).
- keypoint_addr holds its last value when keypoint_re=0. keypoint_addr never exceeds count-1.
- start while busy is ignored and the latched count is unaffected.
- Latency: start in cycle 0 gives keypoint_re/addr 0 in cycle 1, data captured at the end of cycle 2, kp_valid in cycle 3.
- Throughput: one keypoint per cycle when kp_ready is held high.
- Reset mid-operation aborts immediately: FIFO flushed, no done pulse.

Decomposition:
- Shared package keypoint_pkg holds:
  - KP_ADDR_W=11, KP_ROW_W=9, KP_COL_W=10.
  - Field slice positions ROW_MSB=18, ROW_LSB=10, COL_MSB=9, COL_LSB=0.
  - A packed keypoint struct {row, col}, which the detect/filter writer also uses.
- One sub-module: kp_sync_fifo (parameterised depth/width synchronous FIFO exposing occupancy).
- FSM, credit logic and counters live in keypoint_reader.

Test Plan:
- Preload addr 0..4 with {row=i+1, col=2*i+3}; start, kp_count=5, kp_ready=1 → five beats on consecutive cycles from cycle 3; kp_row 1..5, kp_col 3,5,7,9,11; kp_last only on beat 5; done one cycle after beat 5.
- kp_count=0 → no keypoint_re, no kp_valid, done pulses within 2 cycles of start.
- kp_count=10 with kp_ready toggling 1,0,0,1 repeatedly → all 10 values delivered in order with none lost or duplicated; outputs stable while stalled; FIFO occupancy never exceeds 4.
- kp_ready=0 for 20 cycles after start with kp_count=8 → exactly 4 reads issued (addr 0..3), then keypoint_re stays low until kp_ready rises.
- Second start pulse mid-stream, and kp_count=4095 → second start ignored; count saturates to 2048, last address read is 2047, kp_last on beat 2048.
- rst_n asserted low asynchronously mid-stream (not on a clock edge) → kp_valid, busy and keypoint_re drop to 0 immediately; no done pulse; a fresh start after release streams from addr 0.

Source files
------------

// File: rtl/keypoint_pkg.sv
// +----------------------------------------------------------------------+
// | keypoint_pkg : shared keypoint widths, field slices, record, states   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package keypoint_pkg;

    localparam int KP_ADDR_W = 11;
    localparam int KP_ROW_W  = 9;
    localparam int KP_COL_W  = 10;
    localparam int KP_WORD_W = KP_ROW_W + KP_COL_W;

    localparam int ROW_MSB = 18;
    localparam int ROW_LSB = 10;
    localparam int COL_MSB = 9;
    localparam int COL_LSB = 0;

    typedef struct packed {
        logic [KP_ROW_W-1:0] row;
        logic [KP_COL_W-1:0] col;
    } keypoint_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } kp_state_t;

    function automatic keypoint_t kp_unpack(input logic [KP_WORD_W-1:0] i_word);
        keypoint_t w_kp;
        w_kp.row = i_word[ROW_MSB:ROW_LSB];
        w_kp.col = i_word[COL_MSB:COL_LSB];
        return w_kp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kp_sync_fifo.sv
// +----------------------------------------------------------------------+
// | kp_sync_fifo : synchronous FIFO with registered storage and occupancy |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module kp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_occ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_occ;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_occ != '0);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_push = i_push && ((int'(r_occ) < DEPTH) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_occ <= r_occ + OCC_ONE;
            end else if (!w_do_push && w_do_pop) begin
                r_occ <= r_occ - OCC_ONE;
            end
        end
    end

    assign o_dout = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

`default_nettype wire

// File: rtl/keypoint_reader.sv
// +----------------------------------------------------------------------+
// | keypoint_reader : streams keypoint SRAM entries as row/col beats      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module keypoint_reader
    import keypoint_pkg::*;
#(
    parameter int ADDR_W     = KP_ADDR_W,
    parameter int ROW_W      = KP_ROW_W,
    parameter int COL_W      = KP_COL_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W:0]        kp_count,
    output logic                   busy,
    output logic                   done,
    output logic                   keypoint_re,
    output logic [ADDR_W-1:0]      keypoint_addr,
    input  logic [ROW_W+COL_W-1:0] keypoint_dout,
    output logic                   kp_valid,
    input  logic                   kp_ready,
    output logic [ROW_W-1:0]       kp_row,
    output logic [COL_W-1:0]       kp_col,
    output logic                   kp_last
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};

    kp_state_t               r_state;
    kp_state_t               w_state_nxt;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        r_rd_idx;
    logic [CNT_W-1:0]        r_out_idx;
    logic                    r_inflight;
    logic [ADDR_W-1:0]       r_addr_hold;
    logic [CNT_W-1:0]        w_start_cnt;
    logic [OCC_W-1:0]        w_occ;
    logic [OCC_W:0]          w_credit_used;
    logic                    w_space;
    logic                    w_pop;
    logic                    w_issue;
    logic [ROW_W+COL_W-1:0]  w_head;

    assign w_start_cnt = (kp_count > MAX_CNT) ? MAX_CNT : kp_count;
    assign w_pop       = kp_valid && kp_ready;

    // Credits: entries held plus the read whose data lands next cycle, less the beat leaving now.
    assign w_credit_used = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight}
                         - {{OCC_W{1'b0}}, w_pop};
    assign w_space = int'(w_credit_used) < FIFO_DEPTH;
    assign w_issue = (r_state == ST_READ) && (r_rd_idx < r_count) && w_space;

    always_comb begin
        w_state_nxt   = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        keypoint_re   = 1'b0;
        keypoint_addr = r_addr_hold;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_start_cnt == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                busy = 1'b1;
                if (w_issue) begin
                    keypoint_re   = 1'b1;
                    keypoint_addr = r_rd_idx[ADDR_W-1:0];
                    if ((r_rd_idx + ONE_CNT) == r_count) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (kp_last && kp_ready) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_rd_idx    <= '0;
            r_out_idx   <= '0;
            r_inflight  <= 1'b0;
            r_addr_hold <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if ((r_state == ST_IDLE) && start) begin
                r_count   <= w_start_cnt;
                r_rd_idx  <= '0;
                r_out_idx <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_idx    <= r_rd_idx + ONE_CNT;
                    r_addr_hold <= r_rd_idx[ADDR_W-1:0];
                end
                if (w_pop) begin
                    r_out_idx <= r_out_idx + ONE_CNT;
                end
            end
        end
    end

    kp_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ROW_W + COL_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_din  (keypoint_dout),
        .i_pop  (w_pop),
        .o_dout (w_head),
        .o_occ  (w_occ)
    );

    assign kp_valid = (w_occ != '0);
    assign kp_row   = w_head[ROW_W+COL_W-1:COL_W];
    assign kp_col   = w_head[COL_W-1:0];
    assign kp_last  = kp_valid && (r_out_idx == (r_count - ONE_CNT));

endmodule

`default_nettype wire

// File: tb/tb_keypoint_reader.sv
// +----------------------------------------------------------------------+
// | tb_keypoint_reader : directed bench for keypoint_reader               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_keypoint_reader;

    localparam int ADDR_W = 11;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [ADDR_W:0]        kp_count = '0;
    logic                   busy;
    logic                   done;
    logic                   keypoint_re;
    logic [ADDR_W-1:0]      keypoint_addr;
    logic [ROW_W+COL_W-1:0] keypoint_dout = '0;
    logic                   kp_valid;
    logic                   kp_ready = 1'b0;
    logic [ROW_W-1:0]       kp_row;
    logic [COL_W-1:0]       kp_col;
    logic                   kp_last;

    keypoint_reader u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .kp_count      (kp_count),
        .busy          (busy),
        .done          (done),
        .keypoint_re   (keypoint_re),
        .keypoint_addr (keypoint_addr),
        .keypoint_dout (keypoint_dout),
        .kp_valid      (kp_valid),
        .kp_ready      (kp_ready),
        .kp_row        (kp_row),
        .kp_col        (kp_col),
        .kp_last       (kp_last)
    );

    always #5 clk = ~clk;

    // SRAM model: entry i = {row=i+1, col=2i+3}, one-cycle read latency
    logic [ROW_W+COL_W-1:0] sram [2048];
    always @(posedge clk) begin
        if (keypoint_re) keypoint_dout <= sram[keypoint_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) kp_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end

    int n_pass = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [ROW_W-1:0] exp_row(input int i);
        return ROW_W'(i + 1);
    endfunction

    function automatic logic [COL_W-1:0] exp_col(input int i);
        return COL_W'(2 * i + 3);
    endfunction

    // Monitor state
    logic [ROW_W-1:0] q_row [$];
    logic [COL_W-1:0] q_col [$];
    logic             q_last [$];
    int               q_cyc [$];
    int n_reads, n_pops, n_done, max_out, addr_err, stab_err;
    int first_re_cyc, done_cyc, last_addr;
    logic prev_stall;
    logic [ROW_W-1:0] prev_row;
    logic [COL_W-1:0] prev_col;
    int t0;

    task automatic clear_mon();
        q_row.delete(); q_col.delete(); q_last.delete(); q_cyc.delete();
        n_reads = 0; n_pops = 0; n_done = 0; max_out = 0;
        addr_err = 0; stab_err = 0; first_re_cyc = -1; done_cyc = -1;
        last_addr = -1; prev_stall = 1'b0; prev_row = '0; prev_col = '0;
    endtask

    always @(negedge clk) begin
        if (keypoint_re) begin
            if (int'(keypoint_addr) != n_reads) addr_err++;
            if (n_reads == 0) first_re_cyc = cyc;
            last_addr = int'(keypoint_addr);
            n_reads++;
        end
        if (kp_valid && kp_ready) begin
            q_row.push_back(kp_row);
            q_col.push_back(kp_col);
            q_last.push_back(kp_last);
            q_cyc.push_back(cyc);
            n_pops++;
        end
        if ((n_reads - n_pops) > max_out) max_out = n_reads - n_pops;
        if (prev_stall && (!kp_valid || kp_row != prev_row || kp_col != prev_col)) stab_err++;
        prev_stall = kp_valid && !kp_ready;
        prev_row   = kp_row;
        prev_col   = kp_col;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic start_run(input int cnt);
        @(posedge clk);
        #1;
        clear_mon();
        kp_count = (ADDR_W+1)'(cnt);
        start    = 1'b1;
        t0       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int cnt);
        int d_err, l_cnt;
        d_err = 0;
        l_cnt = 0;
        chk({tag, "_beats"}, 32'(q_row.size()), 32'(cnt));
        for (int i = 0; i < q_row.size(); i++) begin
            if (q_row[i] != exp_row(i) || q_col[i] != exp_col(i)) d_err++;
            if (q_last[i]) l_cnt++;
        end
        chk({tag, "_data_err"}, 32'(d_err), 32'd0);
        chk({tag, "_last_cnt"}, 32'(l_cnt), 32'(cnt > 0 ? 1 : 0));
        if (q_last.size() == cnt && cnt > 0) chk({tag, "_last_on_final"}, 32'(q_last[cnt-1]), 32'd1);
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        chk({tag, "_done_cnt"}, 32'(n_done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            sram[i] = {exp_row(i), exp_col(i)};
        end
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_re", 32'(keypoint_re), 32'd0);
        chk("rst_addr", 32'(keypoint_addr), 32'd0);
        chk("rst_valid", 32'(kp_valid), 32'd0);
        chk("rst_rowcol", {13'd0, kp_row, kp_col}, 32'd0);
        chk("rst_last", 32'(kp_last), 32'd0);
        rst_n = 1'b1;

        // Five keypoints, full throughput
        kp_ready = 1'b1;
        start_run(5);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 40);
        check_stream("t1", 5);
        chk("t1_first_re_cyc", 32'(first_re_cyc - t0), 32'd1);
        for (int i = 0; i < q_cyc.size(); i++) begin
            chk($sformatf("t1_beat%0d_cyc", i), 32'(q_cyc[i] - t0), 32'(3 + i));
            chk($sformatf("t1_beat%0d_last", i), 32'(q_last[i]), 32'(i == 4));
        end
        chk("t1_done_cyc", 32'(done_cyc - t0), 32'd8);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Zero count
        start_run(0);
        wait_done("t2", 10);
        chk("t2_reads", 32'(n_reads), 32'd0);
        chk("t2_beats", 32'(n_pops), 32'd0);
        chk("t2_done_within2", 32'((done_cyc - t0) <= 2), 32'd1);
        chk("t2_done_cnt", 32'(n_done), 32'd1);

        // Ten keypoints with ready pattern 1,0,0,1
        rdy_mode = 1;
        start_run(10);
        wait_done("t3", 200);
        check_stream("t3", 10);
        chk("t3_stable", 32'(stab_err), 32'd0);
        chk("t3_max_occ_le4", 32'(max_out <= 4), 32'd1);
        rdy_mode = 0;

        // Downstream stalled for 20 cycles
        kp_ready = 1'b0;
        start_run(8);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_reads_stalled", 32'(n_reads), 32'd4);
        chk("t4_last_addr", 32'(last_addr), 32'd3);
        chk("t4_re_low", 32'(keypoint_re), 32'd0);
        chk("t4_no_beats", 32'(n_pops), 32'd0);
        chk("t4_valid_held", 32'(kp_valid), 32'd1);
        kp_ready = 1'b1;
        wait_done("t4", 100);
        check_stream("t4", 8);
        chk("t4_stable", 32'(stab_err), 32'd0);

        // Saturated count with a second start mid-stream
        start_run(4095);
        repeat (100) @(posedge clk);
        #1;
        kp_count = 12'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t5", 3000);
        check_stream("t5", 2048);
        chk("t5_reads", 32'(n_reads), 32'd2048);
        chk("t5_last_addr", 32'(last_addr), 32'd2047);
        if (q_cyc.size() == 2048) chk("t5_throughput", 32'(q_cyc[2047] - q_cyc[0]), 32'd2047);
        chk("t5_idle_after", 32'(busy), 32'd0);

        // Asynchronous reset mid-stream, then a fresh run
        start_run(10);
        repeat (5) @(posedge clk);
        #3;
        chk("t6_pre_valid", 32'(kp_valid), 32'd1);
        chk("t6_pre_re", 32'(keypoint_re), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(kp_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_re", 32'(keypoint_re), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", 32'(n_done), 32'd0);
        start_run(3);
        wait_done("t6", 40);
        check_stream("t6", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
